// File: rtl/util_arbitsched_pkg.sv
// util_arbitsched shared types: per-channel state encoding and error bit indices.
// Optional aging is enabled by defining UTIL_ARBITSCHED_AGING_EN.
package util_arbitsched_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_SEND = 2'd2
    } chan_state_t;

    localparam int ERR_ENQ_OVF  = 0;
    localparam int ERR_GNT_LOST = 1;
    localparam int ERR_W        = 2;

endpackage

// File: rtl/util_arbitsched_chan.sv
// util_arbitsched_chan: one channel's FSM, pending-packet counter and wait age.
// Age counter and level escalation exist only with UTIL_ARBITSCHED_AGING_EN.
module util_arbitsched_chan
    import util_arbitsched_pkg::*;
#(
    parameter int ARBIT_LEVEL = 2,
    parameter int PEND_WIDTH  = 4,
    parameter int AGE_WIDTH   = 8,
    parameter int AGE_LIMIT   = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enq,
    input  logic                   i_eop,
    input  logic                   i_grant,
    output logic [ARBIT_LEVEL-1:0] o_request,
    output logic                   o_arbit_eop,
    output logic                   o_rd_req,
    output logic                   o_pend_full,
    output logic                   o_err_ovf,
    output logic                   o_err_lost
);

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    chan_state_t             r_state;
    chan_state_t             w_state_nxt;
    logic [PEND_WIDTH-1:0]   r_pend;
    logic [PEND_WIDTH-1:0]   w_pend_nxt;
    logic                    r_pend_full;
    logic                    w_rd_req;
    logic                    w_eop;
    logic                    w_ovf;
    logic                    w_lost;
    logic                    w_old;
    logic [ARBIT_LEVEL-1:0]  w_request;

    // Read only while sending and still granted; eop releases the grant at once.
    assign w_rd_req = (r_state == CH_SEND) & i_grant;
    assign w_eop    = w_rd_req & i_eop;

    // Pending count: enqueue and completed packet in one cycle cancel out.
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf      = 1'b0;
        case ({i_enq, w_eop})
            2'b10: begin
                if (r_pend == PEND_MAX) begin
                    w_ovf = 1'b1;
                end else begin
                    w_pend_nxt = r_pend + 1'b1;
                end
            end
            2'b01: begin
                if (r_pend != '0) begin
                    w_pend_nxt = r_pend - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next-state: leaving SEND looks at the updated count so a same-cycle
    // enqueue keeps the channel waiting instead of bouncing through IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_lost      = 1'b0;
        case (r_state)
            CH_IDLE: begin
                if (r_pend != '0) begin
                    w_state_nxt = CH_WAIT;
                end
            end
            CH_WAIT: begin
                if (i_grant) begin
                    w_state_nxt = CH_SEND;
                end
            end
            CH_SEND: begin
                if (w_eop) begin
                    w_state_nxt = (w_pend_nxt != '0) ? CH_WAIT : CH_IDLE;
                end else if (!i_grant) begin
                    w_state_nxt = CH_WAIT;
                    w_lost      = 1'b1;
                end
            end
            default: w_state_nxt = CH_IDLE;
        endcase
    end

    // State, pending count and registered full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CH_IDLE;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_full <= (w_pend_nxt == PEND_MAX);
        end
    end

`ifdef UTIL_ARBITSCHED_AGING_EN
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
    localparam logic [AGE_WIDTH-1:0] AGE_LIM = AGE_WIDTH'(AGE_LIMIT);

    logic [AGE_WIDTH-1:0] r_age;

    // Age counts saturating while the channel keeps waiting; zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if ((r_state == CH_WAIT) && (w_state_nxt == CH_WAIT)) begin
            if (r_age != AGE_MAX) begin
                r_age <= r_age + 1'b1;
            end
        end else begin
            r_age <= '0;
        end
    end

    assign w_old = (r_age >= AGE_LIM);
`else
    localparam int unused_age_cfg = AGE_WIDTH + AGE_LIMIT;

    assign w_old = 1'b0;
`endif

    // One-hot request level while waiting; escalated level once aged out.
    always_comb begin
        w_request = '0;
        if (r_state == CH_WAIT) begin
            if (w_old) begin
                w_request[ARBIT_LEVEL-1] = 1'b1;
            end else begin
                w_request[0] = 1'b1;
            end
        end
    end

    assign o_request   = w_request;
    assign o_arbit_eop = w_eop;
    assign o_rd_req    = w_rd_req;
    assign o_pend_full = r_pend_full;
    assign o_err_ovf   = w_ovf;
    assign o_err_lost  = w_lost;

endmodule

// File: rtl/util_arbitsched.sv
// util_arbitsched: per-channel packet scheduler feeding an arbitrating mux.
// Define UTIL_ARBITSCHED_AGING_EN to enable wait-age request escalation.
module util_arbitsched
    import util_arbitsched_pkg::*;
#(
    parameter int CHANNEL_QTY = 6,
    parameter int ARBIT_LEVEL = 2,
    parameter int PEND_WIDTH  = 4,
    parameter int AGE_WIDTH   = 8,
    parameter int AGE_LIMIT   = 200
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [CHANNEL_QTY-1:0]                  pkt_enq,
    input  logic [CHANNEL_QTY-1:0]                  pkt_eop,
    input  logic [CHANNEL_QTY-1:0]                  arbit_grant,
    output logic [CHANNEL_QTY-1:0][ARBIT_LEVEL-1:0] arbit_request,
    output logic [CHANNEL_QTY-1:0]                  arbit_eop,
    output logic [CHANNEL_QTY-1:0]                  rd_req,
    output logic [CHANNEL_QTY-1:0]                  pend_full,
    output logic [ERR_W-1:0]                        sched_err
);

    logic [CHANNEL_QTY-1:0] w_ovf;
    logic [CHANNEL_QTY-1:0] w_lost;
    logic [ERR_W-1:0]       r_sched_err;

    for (genvar c = 0; c < CHANNEL_QTY; c++) begin : g_chan
        util_arbitsched_chan #(
            .ARBIT_LEVEL (ARBIT_LEVEL),
            .PEND_WIDTH  (PEND_WIDTH),
            .AGE_WIDTH   (AGE_WIDTH),
            .AGE_LIMIT   (AGE_LIMIT)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_enq       (pkt_enq[c]),
            .i_eop       (pkt_eop[c]),
            .i_grant     (arbit_grant[c]),
            .o_request   (arbit_request[c]),
            .o_arbit_eop (arbit_eop[c]),
            .o_rd_req    (rd_req[c]),
            .o_pend_full (pend_full[c]),
            .o_err_ovf   (w_ovf[c]),
            .o_err_lost  (w_lost[c])
        );
    end

    // Sticky error flags collected from every channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sched_err <= '0;
        end else begin
            r_sched_err[ERR_ENQ_OVF]  <= r_sched_err[ERR_ENQ_OVF]  | (|w_ovf);
            r_sched_err[ERR_GNT_LOST] <= r_sched_err[ERR_GNT_LOST] | (|w_lost);
        end
    end

    assign sched_err = r_sched_err;

endmodule

// File: tb/tb_util_arbitsched.sv
// Directed bench for util_arbitsched (PEND_WIDTH=2 so overflow is reachable).
// Level expectations follow UTIL_ARBITSCHED_AGING_EN.
module tb_util_arbitsched;

    localparam int CH = 6;
    localparam int AL = 2;

`ifdef UTIL_ARBITSCHED_AGING_EN
    localparam logic [1:0] LVL_HI = 2'b10;
`else
    localparam logic [1:0] LVL_HI = 2'b01;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH-1:0]        pkt_enq;
    logic [CH-1:0]        pkt_eop;
    logic [CH-1:0]        arbit_grant;
    logic [CH-1:0][AL-1:0] arbit_request;
    logic [CH-1:0]        arbit_eop;
    logic [CH-1:0]        rd_req;
    logic [CH-1:0]        pend_full;
    logic [1:0]           sched_err;

    int checks = 0;
    int errors = 0;

    util_arbitsched #(
        .CHANNEL_QTY (CH),
        .ARBIT_LEVEL (AL),
        .PEND_WIDTH  (2),
        .AGE_WIDTH   (8),
        .AGE_LIMIT   (200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_enq       (pkt_enq),
        .pkt_eop       (pkt_eop),
        .arbit_grant   (arbit_grant),
        .arbit_request (arbit_request),
        .arbit_eop     (arbit_eop),
        .rd_req        (rd_req),
        .pend_full     (pend_full),
        .sched_err     (sched_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pkt(input int ch, input int beats);
        arbit_grant[ch] = 1'b1;
        tick();
        chk("send_req_zero", 32'(arbit_request[ch]), 32'd0);
        for (int b = 1; b <= beats; b++) begin
            pkt_eop[ch] = (b == beats);
            #1;
            chk("send_rd_req", 32'(rd_req[ch]), 32'd1);
            chk("send_eop", 32'(arbit_eop[ch]), 32'(b == beats));
            tick();
        end
        arbit_grant[ch] = 1'b0;
        pkt_eop[ch]     = 1'b0;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        pkt_enq     = '0;
        pkt_eop     = '0;
        arbit_grant = '0;
        tick();
        tick();
        chk("rst_req", 32'(arbit_request), 32'd0);
        chk("rst_rd", 32'(rd_req), 32'd0);
        chk("rst_eop", 32'(arbit_eop), 32'd0);
        chk("rst_full", 32'(pend_full), 32'd0);
        chk("rst_err", 32'(sched_err), 32'd0);
        rst = 1'b0;
        tick();

        // single enqueue on ch2, 4-beat packet
        pkt_enq[2] = 1'b1;
        tick();
        pkt_enq[2] = 1'b0;
        #1;
        chk("c2_idle_req", 32'(arbit_request[2]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c2_wait_req", 32'(arbit_request[2]), 32'd1);
            chk("c2_wait_rd", 32'(rd_req[2]), 32'd0);
        end
        pkt(2, 4);
        chk("c2_done_req", 32'(arbit_request[2]), 32'd0);
        chk("c2_done_rd", 32'(rd_req[2]), 32'd0);

        // back-to-back on ch0
        pkt_enq[0] = 1'b1;
        tick();
        tick();
        tick();
        pkt_enq[0] = 1'b0;
        #1;
        chk("c0_full", 32'(pend_full[0]), 32'd1);
        chk("c0_wait3", 32'(arbit_request[0]), 32'd1);
        pkt(0, 2);
        chk("c0_wait2", 32'(arbit_request[0]), 32'd1);
        chk("c0_notfull", 32'(pend_full[0]), 32'd0);
        pkt(0, 1);
        chk("c0_wait1", 32'(arbit_request[0]), 32'd1);
        pkt(0, 3);
        chk("c0_idle", 32'(arbit_request[0]), 32'd0);
        chk("c0_err", 32'(sched_err), 32'd0);

        // aging on ch1
        pkt_enq[1] = 1'b1;
        tick();
        pkt_enq[1] = 1'b0;
        tick();
        chk("c1_age0", 32'(arbit_request[1]), 32'd1);
        repeat (199) tick();
        chk("c1_age199", 32'(arbit_request[1]), 32'd1);
        tick();
        chk("c1_age200", 32'(arbit_request[1]), 32'(LVL_HI));
        repeat (100) tick();
        chk("c1_age_sat", 32'(arbit_request[1]), 32'(LVL_HI));
        pkt(1, 1);
        chk("c1_idle", 32'(arbit_request[1]), 32'd0);
        pkt_enq[1] = 1'b1;
        tick();
        pkt_enq[1] = 1'b0;
        tick();
        chk("c1_age_clr", 32'(arbit_request[1]), 32'd1);
        pkt(1, 1);

        // overflow on ch3
        pkt_enq[3] = 1'b1;
        tick();
        tick();
        tick();
        pkt_enq[3] = 1'b0;
        #1;
        chk("c3_full", 32'(pend_full[3]), 32'd1);
        chk("c3_err0", 32'(sched_err), 32'd0);
        arbit_grant[3] = 1'b1;
        tick();
        pkt_eop[3] = 1'b1;
        pkt_enq[3] = 1'b1;
        #1;
        chk("c3_enq_eop", 32'(arbit_eop[3]), 32'd1);
        tick();
        pkt_eop[3]     = 1'b0;
        pkt_enq[3]     = 1'b0;
        arbit_grant[3] = 1'b0;
        #1;
        chk("c3_still_full", 32'(pend_full[3]), 32'd1);
        chk("c3_no_err", 32'(sched_err), 32'd0);
        chk("c3_wait", 32'(arbit_request[3]), 32'd1);
        pkt_enq[3] = 1'b1;
        tick();
        pkt_enq[3] = 1'b0;
        #1;
        chk("c3_ovf_err", 32'(sched_err), 32'd1);
        chk("c3_ovf_full", 32'(pend_full[3]), 32'd1);
        pkt(3, 1);
        chk("c3_drain1", 32'(pend_full[3]), 32'd0);
        pkt(3, 1);
        chk("c3_drain2", 32'(arbit_request[3]), 32'd1);
        pkt(3, 1);
        chk("c3_drained", 32'(arbit_request[3]), 32'd0);

        // grant loss on ch4
        pkt_enq[4] = 1'b1;
        tick();
        pkt_enq[4] = 1'b0;
        tick();
        arbit_grant[4] = 1'b1;
        tick();
        chk("c4_rd1", 32'(rd_req[4]), 32'd1);
        tick();
        chk("c4_rd2", 32'(rd_req[4]), 32'd1);
        arbit_grant[4] = 1'b0;
        #1;
        chk("c4_rd_drop", 32'(rd_req[4]), 32'd0);
        chk("c4_no_eop", 32'(arbit_eop[4]), 32'd0);
        tick();
        chk("c4_rewait", 32'(arbit_request[4]), 32'd1);
        chk("c4_err", 32'(sched_err), 32'd3);
        pkt(4, 1);
        chk("c4_idle", 32'(arbit_request[4]), 32'd0);

        // reset mid-SEND on ch5
        pkt_enq[5] = 1'b1;
        tick();
        pkt_enq[5] = 1'b0;
        tick();
        arbit_grant[5] = 1'b1;
        tick();
        chk("c5_send", 32'(rd_req[5]), 32'd1);
        rst = 1'b1;
        #1;
        chk("c5_rst_req", 32'(arbit_request), 32'd0);
        chk("c5_rst_rd", 32'(rd_req), 32'd0);
        chk("c5_rst_eop", 32'(arbit_eop), 32'd0);
        chk("c5_rst_full", 32'(pend_full), 32'd0);
        chk("c5_rst_err", 32'(sched_err), 32'd0);
        tick();
        rst            = 1'b0;
        arbit_grant[5] = 1'b0;
        tick();
        chk("c5_post_idle", 32'(arbit_request[5]), 32'd0);
        pkt_enq[5] = 1'b1;
        tick();
        pkt_enq[5] = 1'b0;
        tick();
        chk("c5_post_wait", 32'(arbit_request[5]), 32'd1);
        pkt(5, 2);
        chk("c5_post_done", 32'(arbit_request[5]), 32'd0);
        chk("final_err", 32'(sched_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
